uart_tx_fifo_drain: RTL and testbench
=====================================

Name: uart_tx_fifo_drain

Overview:
Serial transmitter stage directly downstream of the 8-bit byte FIFO. Whenever the FIFO is non-empty, it pops one byte and sends it as an 8N1 UART frame on a single line, LSB first. The handshake is single-cycle: capture the byte and pulse the FIFO read trigger in the same cycle. The block sits between the FIFO and the physical TX pin of the FPGA communication link.

Parameters:
CLKS_PER_BIT, 434, clk cycles per serial bit (50 MHz / 115200 baud); legal range >= 2.

Ports:
clk  input  1  system clock; all logic on its rising edge
rst  input  1  synchronous active-high reset
fifo_dout  input  8  head byte of the FIFO; valid whenever fifo_empty=0
fifo_empty  input  1  FIFO holds no data
fifo_trig_read  output  1  one-cycle pop pulse to the FIFO read trigger
tx  output  1  serial line; idle high
busy  output  1  high for the full duration of a frame

Behaviour:
- Clocking: one clock (clk); reset rst is synchronous and active-high.
- All outputs are registered.
- Reset values: tx=1, busy=0, fifo_trig_read=0, state=IDLE, baud counter=0, bit index=0, shift register=0.
- States: IDLE, START, DATA, STOP.
- IDLE:
  - tx=1, busy=0.
  - On an edge with fifo_empty=0: latch fifo_dout into the shift register, set fifo_trig_read=1, tx=0, busy=1, baud counter=0, go to START.
- fifo_trig_read is high for exactly one cycle and is cleared on the next edge unconditionally.
- The FIFO is never popped while fifo_empty=1.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0; tx = shift[0].
- DATA:
  - Each bit is held for CLKS_PER_BIT cycles.
  - At counter terminal (CLKS_PER_BIT-1): if bit index < 7, increment it and drive the next bit (LSB first).
  - At bit 7 terminal: go to STOP with tx=1.
- STOP: tx=1 for CLKS_PER_BIT cycles; at terminal go to IDLE, busy=0.
- Frame timing:
  - A frame lasts exactly 10*CLKS_PER_BIT cycles, counted from the first cycle with tx=0. busy is high throughout.
  - At least one IDLE cycle (tx=1, busy=0) separates back-to-back frames.
  - Consecutive fifo_trig_read pulses are therefore exactly 10*CLKS_PER_BIT+1 cycles apart when the FIFO stays non-empty.
- Latency: fifo_empty sampled low at edge E → fifo_trig_read=1 and tx=0 in the cycle following E.
- Data is latched at pop. Later changes on fifo_dout or fifo_empty during a frame have no effect.
- Counter width: $clog2(CLKS_PER_BIT). It wraps to 0 at terminal and never exceeds CLKS_PER_BIT-1.
- Reset mid-frame:
  - On the reset edge all registers return to reset values: tx=1 the next cycle and the frame is aborted.
  - The popped byte is discarded and is not re-read.
  - The first IDLE evaluation happens on the first edge with rst=0.
- Reset concurrent with fifo_empty=0 in IDLE: reset wins; no pop.

Decomposition:
- Shared package holds:
  - state enum (IDLE, START, DATA, STOP) as a 2-bit typedef;
  - constants DATA_BITS=8 and DEFAULT_CLKS_PER_BIT=434.
- One natural sub-module: uart_baud_counter.
  - Parameter: CLKS_PER_BIT.
  - Inputs: clk, rst, clear.
  - Output: tick, high on the terminal count.
- The FSM, shift register and bit index stay in the top module.

Test Plan:
All scenarios run with CLKS_PER_BIT=4 and a behavioural FIFO model that pops on fifo_trig_read.
1. Reset: rst=1 for 3 cycles with fifo_empty=0 → tx=1, busy=0, fifo_trig_read=0 throughout; no pop.
2. Single byte 0xA5 queued:
   - one fifo_trig_read pulse;
   - tx, 4 cycles each: 0, then 1,0,1,0,0,1,0,1, then 1;
   - busy high 40 cycles, then low;
   - FIFO empty afterwards, tx stays 1.
3. Back-to-back 0x00 then 0xFF:
   - two fifo_trig_read pulses exactly 41 cycles apart;
   - one idle cycle with tx=1, busy=0 between frames;
   - second frame data bits all 1.
4. fifo_empty held 1 for 200 cycles → fifo_trig_read never asserts, tx=1, busy=0.
5. Abort: rst=1 for 1 cycle during data bit 3 of 0x3C, with 0x81 queued behind it:
   - next cycle tx=1, busy=0;
   - after release, 0x81 is popped and sent in full;
   - 0x3C is never re-sent.
6. Stable latch: the FIFO model changes fifo_dout to 0xFF immediately after popping 0x12 → serialized bits are 0,1,0,0,1,0,0,0 (0x12 LSB first).

Source files
------------

// File: rtl/uart_tx_fifo_drain_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo_drain_pkg
// Description : Shared types and constants for the FIFO-draining UART sender.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_tx_fifo_drain_pkg;

    localparam int DATA_BITS            = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 434;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

endpackage : uart_tx_fifo_drain_pkg
`default_nettype wire

// File: rtl/uart_tx_fifo_drain_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo_drain_if
// Description : FIFO read-side handshake (head byte, empty flag, pop pulse).
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_fifo_drain_if;
    import uart_tx_fifo_drain_pkg::*;

    logic [DATA_BITS-1:0] fifo_dout;
    logic                 fifo_empty;
    logic                 fifo_trig_read;

    // master pops the FIFO, slave is the FIFO itself
    modport master (
        input  fifo_dout,
        input  fifo_empty,
        output fifo_trig_read
    );

    modport slave (
        output fifo_dout,
        output fifo_empty,
        input  fifo_trig_read
    );

endinterface : uart_tx_fifo_drain_if
`default_nettype wire

// File: rtl/uart_tx_fifo_drain_baud_counter.sv
`default_nettype none
// ============================================================================
// Module      : uart_baud_counter
// Description : Free-running bit-period counter; tick marks the last cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_counter #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int          CNT_W  = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_tick;

    assign w_tick = (r_cnt == c_LAST);
    assign tick   = w_tick;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule : uart_baud_counter
`default_nettype wire

// File: rtl/uart_tx_fifo_drain.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo_drain
// Description : Pops bytes from a FIFO and sends each as an 8N1 frame, LSB first.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo_drain
    import uart_tx_fifo_drain_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                       clk,
    input  logic                       rst,
    uart_tx_fifo_drain_if.master       fifo,
    output logic                       tx,
    output logic                       busy
);

    localparam int               IDX_W      = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(DATA_BITS - 1);

    state_t               r_state;
    logic [DATA_BITS-1:0] r_shift;
    logic [IDX_W-1:0]     r_bit_idx;
    logic                 r_tx;
    logic                 r_busy;
    logic                 r_trig;
    logic                 w_tick;
    logic                 w_clear;

    // Holding the counter at zero while idle aligns it with the start bit.
    assign w_clear = (r_state == IDLE);

    uart_baud_counter #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk   (clk),
        .rst   (rst),
        .clear (w_clear),
        .tick  (w_tick)
    );

    assign tx                  = r_tx;
    assign busy                = r_busy;
    assign fifo.fifo_trig_read = r_trig;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
            r_trig    <= 1'b0;
        end else begin
            r_trig <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_tx   <= 1'b1;
                    r_busy <= 1'b0;
                    if (!fifo.fifo_empty) begin
                        r_shift <= fifo.fifo_dout;
                        r_trig  <= 1'b1;
                        r_tx    <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= START;
                    end
                end
                START: begin
                    if (w_tick) begin
                        r_tx      <= r_shift[0];
                        r_shift   <= {1'b0, r_shift[DATA_BITS-1:1]};
                        r_bit_idx <= '0;
                        r_state   <= DATA;
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        if (r_bit_idx < c_LAST_IDX) begin
                            // r_shift[0] already holds the next bit after the shift
                            r_bit_idx <= r_bit_idx + IDX_W'(1);
                            r_tx      <= r_shift[0];
                            r_shift   <= {1'b0, r_shift[DATA_BITS-1:1]};
                        end else begin
                            r_tx    <= 1'b1;
                            r_state <= STOP;
                        end
                    end
                end
                STOP: begin
                    if (w_tick) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule : uart_tx_fifo_drain
`default_nettype wire

// File: tb/tb_uart_tx_fifo_drain.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_fifo_drain
// Description : Directed self-checking bench with a behavioural FIFO model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo_drain;

    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;

    logic clk = 1'b0;
    logic rst;
    logic tx;
    logic busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] fq[$];
    logic [7:0] empty_dout = 8'h00;
    logic       pop_empty_seen = 1'b0;

    logic tx_log   [FRAME];
    logic busy_log [FRAME];
    logic trig_log [FRAME];

    uart_tx_fifo_drain_if bus ();

    uart_tx_fifo_drain #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .fifo (bus),
        .tx   (tx),
        .busy (busy)
    );

    always #5 clk = ~clk;

    // FIFO model: pops on the read pulse, presents head/empty away from the edge
    always @(posedge clk) begin
        if (bus.fifo_trig_read === 1'b1) begin
            if (fq.size() == 0) pop_empty_seen = 1'b1;
            else void'(fq.pop_front());
        end
    end

    always @(negedge clk) begin
        bus.fifo_empty = (fq.size() == 0);
        bus.fifo_dout  = (fq.size() == 0) ? empty_dout : fq[0];
    end

    task automatic wait_trig(input int limit, output logic found);
        found = 1'b0;
        for (int i = 0; i < limit && !found; i++) begin
            @(negedge clk);
            found = (bus.fifo_trig_read === 1'b1);
        end
    endtask

    // Records one frame starting at the current negedge (the pop cycle)
    task automatic capture_frame;
        for (int i = 0; i < FRAME; i++) begin
            if (i > 0) @(negedge clk);
            tx_log[i]   = tx;
            busy_log[i] = busy;
            trig_log[i] = bus.fifo_trig_read;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        fq.push_back(8'h55);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (tx !== 1'b1 || busy !== 1'b0 || bus.fifo_trig_read !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs cyc %0d got tx=%b busy=%b trig=%b want 1 0 0",
                         i, tx, busy, bus.fifo_trig_read);
            end
        end
        checks++;
        if (fq.size() !== 1) begin
            errors++;
            $display("FAIL reset_no_pop got fifo_size=%0d want 1", fq.size());
        end
        fq.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single;
        logic       found;
        logic [9:0] exp_f;
        exp_f = {1'b1, 8'hA5, 1'b0};
        fq.push_back(8'hA5);
        wait_trig(20, found);
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL single_pop got no trig want trig");
            return;
        end
        capture_frame();
        for (int i = 0; i < FRAME; i++) begin
            checks++;
            if (tx_log[i] !== exp_f[i / CPB] || busy_log[i] !== 1'b1 ||
                trig_log[i] !== (i == 0)) begin
                errors++;
                $display("FAIL single_frame cyc %0d got tx=%b busy=%b trig=%b want %b 1 %b",
                         i, tx_log[i], busy_log[i], trig_log[i], exp_f[i / CPB], (i == 0));
            end
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (tx !== 1'b1 || busy !== 1'b0 || bus.fifo_trig_read !== 1'b0) begin
                errors++;
                $display("FAIL single_after cyc %0d got tx=%b busy=%b trig=%b want 1 0 0",
                         i, tx, busy, bus.fifo_trig_read);
            end
        end
        checks++;
        if (fq.size() !== 0) begin
            errors++;
            $display("FAIL single_fifo_empty got size=%0d want 0", fq.size());
        end
    endtask

    task automatic test_back_to_back;
        logic       found;
        logic [9:0] exp_a;
        logic [9:0] exp_b;
        exp_a = {1'b1, 8'h00, 1'b0};
        exp_b = {1'b1, 8'hFF, 1'b0};
        fq.push_back(8'h00);
        fq.push_back(8'hFF);
        wait_trig(20, found);
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL b2b_pop got no trig want trig");
            return;
        end
        capture_frame();
        for (int i = 0; i < FRAME; i++) begin
            checks++;
            if (tx_log[i] !== exp_a[i / CPB] || busy_log[i] !== 1'b1) begin
                errors++;
                $display("FAIL b2b_frame1 cyc %0d got tx=%b busy=%b want %b 1",
                         i, tx_log[i], busy_log[i], exp_a[i / CPB]);
            end
        end
        @(negedge clk);
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || bus.fifo_trig_read !== 1'b0) begin
            errors++;
            $display("FAIL b2b_gap got tx=%b busy=%b trig=%b want 1 0 0",
                     tx, busy, bus.fifo_trig_read);
        end
        @(negedge clk);
        checks++;
        if (bus.fifo_trig_read !== 1'b1 || tx !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second_pop_41 got trig=%b tx=%b busy=%b want 1 0 1",
                     bus.fifo_trig_read, tx, busy);
        end
        capture_frame();
        for (int i = 0; i < FRAME; i++) begin
            checks++;
            if (tx_log[i] !== exp_b[i / CPB] || busy_log[i] !== 1'b1) begin
                errors++;
                $display("FAIL b2b_frame2 cyc %0d got tx=%b busy=%b want %b 1",
                         i, tx_log[i], busy_log[i], exp_b[i / CPB]);
            end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_idle_empty;
        int bad;
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || bus.fifo_trig_read !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL idle_empty got %0d bad cycles want 0", bad);
        end
    endtask

    task automatic test_abort;
        logic       found;
        logic [9:0] exp_f;
        int         bad;
        exp_f = {1'b1, 8'h81, 1'b0};
        fq.push_back(8'h3C);
        fq.push_back(8'h81);
        wait_trig(20, found);
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL abort_pop got no trig want trig");
            return;
        end
        repeat (16) @(negedge clk);
        checks++;
        if (tx !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_bit3 got tx=%b busy=%b want 1 1", tx, busy);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || bus.fifo_trig_read !== 1'b0) begin
            errors++;
            $display("FAIL abort_reset got tx=%b busy=%b trig=%b want 1 0 0",
                     tx, busy, bus.fifo_trig_read);
        end
        checks++;
        if (fq.size() !== 1) begin
            errors++;
            $display("FAIL abort_queue got size=%0d want 1", fq.size());
        end
        rst = 1'b0;
        wait_trig(20, found);
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL abort_repop got no trig want trig");
            return;
        end
        capture_frame();
        for (int i = 0; i < FRAME; i++) begin
            checks++;
            if (tx_log[i] !== exp_f[i / CPB] || busy_log[i] !== 1'b1) begin
                errors++;
                $display("FAIL abort_frame_81 cyc %0d got tx=%b busy=%b want %b 1",
                         i, tx_log[i], busy_log[i], exp_f[i / CPB]);
            end
        end
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || bus.fifo_trig_read !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0 || fq.size() !== 0) begin
            errors++;
            $display("FAIL abort_no_resend got bad=%0d size=%0d want 0 0", bad, fq.size());
        end
    endtask

    task automatic test_stable_latch;
        logic       found;
        logic [7:0] exp_bits;
        exp_bits = 8'h12;
        empty_dout = 8'hFF;
        fq.push_back(8'h12);
        wait_trig(20, found);
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL latch_pop got no trig want trig");
            return;
        end
        capture_frame();
        checks++;
        if (bus.fifo_dout !== 8'hFF || bus.fifo_empty !== 1'b1) begin
            errors++;
            $display("FAIL latch_stimulus got dout=%h empty=%b want ff 1",
                     bus.fifo_dout, bus.fifo_empty);
        end
        for (int b = 0; b < 8; b++) begin
            checks++;
            // sample mid-bit so one bad edge cannot hide behind its neighbour
            if (tx_log[(b + 1) * CPB + 1] !== exp_bits[b]) begin
                errors++;
                $display("FAIL latch_bit %0d got %b want %b",
                         b, tx_log[(b + 1) * CPB + 1], exp_bits[b]);
            end
        end
        repeat (5) @(negedge clk);
        empty_dout = 8'h00;
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_single();
        test_back_to_back();
        test_idle_empty();
        test_abort();
        test_stable_latch();
        checks++;
        if (pop_empty_seen !== 1'b0) begin
            errors++;
            $display("FAIL pop_while_empty got %b want 0", pop_empty_seen);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_uart_tx_fifo_drain
`default_nettype wire
